// File: rtl/dmux_pkg.sv
// dmux_pkg: arbiter state encoding and defaults shared with the dmux sender
package dmux_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_e;
    localparam int DMUX_DATA_W  = 8;
    localparam int DMUX_MIN_GAP = 6;
endpackage

// File: rtl/dmux_rr_pick.sv
// dmux_rr_pick: combinational rotating-priority picker, first request at or after start wins
module dmux_rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [N-1:0] rot;
    logic [IW:0]  sum;
    // rotate so start sits at bit 0, then take the lowest set bit and map it back
    always_comb begin
        rot   = N'({req, req} >> start);
        sum   = '0;
        grant = '0;
        idx   = '0;
        any   = |req;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, start} + (IW + 1)'(k);
            if (rot[k]) idx = IW'(sum >= (IW + 1)'(N) ? sum - (IW + 1)'(N) : sum);
        end
        grant[idx] = any;
    end
endmodule

// File: rtl/dmux_tx_arbiter.sv
// dmux_tx_arbiter: shares one dmux CDC sender among requesters; DMUX_ARB_FIXED_PRIO_EN selects fixed priority
module dmux_tx_arbiter
    import dmux_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = DMUX_DATA_W,
    parameter  int MIN_GAP = DMUX_MIN_GAP,
    localparam int IW      = $clog2(NUM_REQ),
    localparam int GW      = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1
) (
    input  logic                      clk_a,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         dmux_data,
    output logic                      dmux_valid,
    output logic [IW-1:0]             dmux_src,
    output logic                      busy
);
    if (MIN_GAP < 1) begin : g_bad_gap
        $error("dmux_tx_arbiter: MIN_GAP must be at least 1");
    end

    state_e               state, state_nx;
    logic [IW-1:0]        rr_ptr, pick_start, pick_idx, ptr_nx;
    logic [NUM_REQ-1:0]   pick_grant;
    logic                 pick_any, accept;
    logic [GW-1:0]        gap_cnt;

`ifdef DMUX_ARB_FIXED_PRIO_EN
    assign pick_start = '0;
    assign ptr_nx     = '0;
`else
    assign pick_start = rr_ptr;
    assign ptr_nx     = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
`endif

    dmux_rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (req_valid),
        .start (pick_start),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign busy = (state != IDLE);

    // next state and the single-cycle accept strobe, which only exists in IDLE outside reset
    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                accept   = pick_any && !rst;
                state_nx = pick_any ? ISSUE : IDLE;
            end
            ISSUE:   state_nx = GAP;
            GAP:     state_nx = (gap_cnt == '0) ? IDLE : GAP;
            default: state_nx = IDLE;
        endcase
        req_ready = accept ? pick_grant : '0;
    end

    // state, captured word/source, pointer and quiet-window counter
    always_ff @(posedge clk_a) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gap_cnt    <= '0;
            dmux_data  <= '0;
            dmux_src   <= '0;
            dmux_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            dmux_valid <= (state_nx == ISSUE);
            if (accept) begin
                dmux_data <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
                dmux_src  <= pick_idx;
                rr_ptr    <= ptr_nx;
            end
            if (state == ISSUE) gap_cnt <= GW'(MIN_GAP - 1);
            else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_dmux_tx_arbiter.sv
// tb_dmux_tx_arbiter: directed checks of the arbiter plus an end-to-end run through a toggle-synchronised slow-side model
module tb_dmux_tx_arbiter;
    logic        clk_a = 1'b0, clk_b = 1'b0, rst = 1'b1, e_rst = 1'b1, mon_en = 1'b0;
    logic [3:0]  req_valid = '0, req_ready, e_valid = '0, e_ready;
    logic [31:0] req_data = '0, e_data = '0;
    logic [7:0]  dmux_data, e_dmux_data;
    logic        dmux_valid, busy, e_dmux_valid, e_busy;
    logic [1:0]  dmux_src, e_src;
    int          total = 0, fails = 0, w;
    logic [7:0]  mem [4][16];
    int          rd [4];
    logic [7:0]  rx_q [$], exp_q [$];
    logic        tog = 1'b0, s1 = 1'b0, s2 = 1'b0;
    logic [3:0]  pv = '0, pr = '0, epv = '0, epr = '0, held, eheld;
    logic [31:0] pd = '0, epd = '0;

    always #5 clk_a = ~clk_a;
    initial begin
        #2;
        forever #20 clk_b = ~clk_b;
    end

    dmux_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .MIN_GAP(6)) dut (
        .clk_a(clk_a), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .dmux_data(dmux_data), .dmux_valid(dmux_valid), .dmux_src(dmux_src), .busy(busy)
    );

    dmux_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .MIN_GAP(13)) u_e2e (
        .clk_a(clk_a), .rst(e_rst), .req_valid(e_valid), .req_data(e_data), .req_ready(e_ready),
        .dmux_data(e_dmux_data), .dmux_valid(e_dmux_valid), .dmux_src(e_src), .busy(e_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // handshake legality and requester data stability on both instances
    always @(negedge clk_a) if (mon_en) begin
        for (int i = 0; i < 4; i++) begin
            held[i]  = pv[i] & ~pr[i] & req_valid[i] & (req_data[i*8 +: 8] != pd[i*8 +: 8]);
            eheld[i] = epv[i] & ~epr[i] & e_valid[i] & (e_data[i*8 +: 8] != epd[i*8 +: 8]);
        end
        total++;
        assert ((req_ready & ~req_valid) === 4'b0 && $onehot0(req_ready) && (req_ready === 4'b0 || busy === 1'b0)
                && (e_ready & ~e_valid) === 4'b0 && $onehot0(e_ready) && (e_ready === 4'b0 || e_busy === 1'b0)
                && held === 4'b0 && eheld === 4'b0) else begin
            fails++;
            $error("FAIL protocol observed ready=%b/%b busy=%b/%b data_change=%b/%b expected legal handshake",
                   req_ready, e_ready, busy, e_busy, held, eheld);
        end
        pv = req_valid; pr = req_ready; pd = req_data;
        epv = e_valid; epr = e_ready; epd = e_data;
    end

    // slow-side model: sender toggles on each valid, receiver syncs the toggle and captures on a change
    always @(posedge clk_a) if (e_dmux_valid === 1'b1) tog <= ~tog;
    always @(posedge clk_b) begin
        s1 <= tog;
        s2 <= s1;
        if (s1 != s2) rx_q.push_back(e_dmux_data);
    end

    initial begin
        req_valid = 4'hF;
        req_data  = 32'h44332211;
        // reset with every requester asking
        for (int r = 0; r < 3; r++) begin
            @(posedge clk_a);
            mon_en = 1'b1;
            @(negedge clk_a);
            chk("rst_ready", req_ready, 0);
            chk("rst_valid", dmux_valid, 0);
            chk("rst_data", dmux_data, 0);
            chk("rst_src", dmux_src, 0);
            chk("rst_busy", busy, 0);
        end
        @(posedge clk_a); #1;
        rst = 1'b0;
        // round-robin with all four valid: accepts 8 cycles apart
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) @(posedge clk_a);
            @(negedge clk_a);
`ifdef DMUX_ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = (k / 8) % 4;
`endif
            chk("rr_ready", req_ready, (k % 8 == 0) ? (32'd1 << w) : 32'd0);
            chk("rr_valid", dmux_valid, (k % 8 == 1) ? 1 : 0);
            chk("rr_busy", busy, (k % 8 != 0) ? 1 : 0);
            if (k % 8 != 0) begin
                chk("rr_data", dmux_data, 32'h11 * (w + 1));
                chk("rr_src", dmux_src, w);
            end
        end
        // hold: no requests after the last issue
        @(posedge clk_a); #1;
        req_valid = 4'b0;
        @(negedge clk_a);
        chk("hold_pulse", dmux_valid, 1);
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk_a);
            chk("hold_valid", dmux_valid, 0);
            chk("hold_data", dmux_data, 32'h11);
            chk("hold_src", dmux_src, 0);
            chk("hold_busy", busy, (j < 7) ? 1 : 0);
            chk("hold_ready", req_ready, 0);
        end
        // single requester 2
        @(posedge clk_a); #1;
        req_data[23:16] = 8'hA5;
        req_valid = 4'b0100;
        @(negedge clk_a);
        chk("single_ready", req_ready, 4'b0100);
        @(posedge clk_a); #1;
        req_valid = 4'b0;
        req_data[23:16] = 8'h5A;
        @(negedge clk_a);
        chk("single_valid", dmux_valid, 1);
        chk("single_data", dmux_data, 8'hA5);
        chk("single_src", dmux_src, 2);
        @(posedge clk_a); #1;
        req_valid = 4'b0100;
        for (int j = 2; j <= 7; j++) begin
            @(negedge clk_a);
            chk("gap_ready", req_ready, 0);
            @(posedge clk_a);
        end
        @(negedge clk_a);
        chk("gap_reaccept", req_ready, 4'b0100);
        @(posedge clk_a); #1;
        req_valid = 4'b0;
        @(negedge clk_a);
        chk("second_data", dmux_data, 8'h5A);
        // reset in the middle of the quiet window
        @(posedge clk_a);
        @(posedge clk_a);
        @(posedge clk_a); #1;
        rst = 1'b1;
        @(negedge clk_a);
        chk("midgap_cnt", dut.gap_cnt, 3);
        chk("midgap_busy", busy, 1);
        @(posedge clk_a); #1;
        rst = 1'b0;
        req_data[15:8]  = 8'hC3;
        req_data[31:24] = 8'h3C;
        req_valid = 4'b1010;
        @(negedge clk_a);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_data", dmux_data, 0);
        chk("post_rst_src", dmux_src, 0);
        chk("post_rst_valid", dmux_valid, 0);
        chk("post_rst_ptr", dut.rr_ptr, 0);
        chk("post_rst_ready", req_ready, 4'b0010);
        @(posedge clk_a); #1;
        req_valid = 4'b0;
        @(negedge clk_a);
        chk("post_rst_issue", dmux_valid, 1);
        chk("post_rst_word", dmux_data, 8'hC3);
        chk("post_rst_owner", dmux_src, 1);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk_a);
            chk("no_extra_valid", dmux_valid, 0);
        end
        // end-to-end: 64 random words through the slow-side model
        for (int i = 0; i < 4; i++) begin
            rd[i] = 0;
            for (int j = 0; j < 16; j++) mem[i][j] = 8'($urandom_range(0, 255));
        end
        @(posedge clk_a); #1;
        e_rst = 1'b0;
        for (int c = 0; c < 3000 && rx_q.size() < 64; c++) begin
            for (int i = 0; i < 4; i++) begin
                e_valid[i] = (rd[i] < 16);
                e_data[i*8 +: 8] = (rd[i] < 16) ? mem[i][rd[i]] : 8'h00;
            end
            @(negedge clk_a);
            for (int i = 0; i < 4; i++)
                if (e_ready[i] === 1'b1 && rd[i] < 16) begin
                    exp_q.push_back(mem[i][rd[i]]);
                    rd[i]++;
                end
            @(posedge clk_a); #1;
        end
        chk("e2e_granted", exp_q.size(), 64);
        chk("e2e_received", rx_q.size(), 64);
        for (int i = 0; i < 64; i++)
            if (i < rx_q.size() && i < exp_q.size()) chk("e2e_word", rx_q[i], exp_q[i]);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
